// File: rtl/regfile_port_sched.sv
// regfile_port_sched: post-reset register sweep, then shares the register-file write port
// between core writeback (top priority) and loader/debug (round-robin).
module regfile_port_sched #(
  parameter logic        INIT_EN = 1'b1,
  parameter logic [31:0] INIT_X8 = 32'h0000_0048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_core_we,
  input  logic [4:0]  i_core_a3,
  input  logic [31:0] i_core_wd,
  output logic        o_core_stall,
  input  logic        i_ld_req,
  input  logic [4:0]  i_ld_addr,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_ack,
  input  logic        i_dbg_req,
  input  logic [4:0]  i_dbg_addr,
  input  logic [31:0] i_dbg_data,
  output logic        o_dbg_ack,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_a3,
  output logic [31:0] o_rf_wd,
  output logic        o_init_done
);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t     r_state;
  logic [4:0] r_cnt;
  logic       r_rr;
  logic       w_init, w_run, w_core, w_ld_gnt, w_dbg_gnt;
  // Outputs are gated by the reset level itself so they drop the instant rst_n falls.
  always_comb begin
    w_init    = i_rst_n && r_state == S_INIT;
    w_run     = i_rst_n && r_state == S_RUN;
    w_core    = w_run && i_core_we;
    w_ld_gnt  = w_run && !i_core_we && i_ld_req && (!i_dbg_req || !r_rr);
    w_dbg_gnt = w_run && !i_core_we && i_dbg_req && (!i_ld_req || r_rr);
    o_rf_we   = w_init || w_core || w_ld_gnt || w_dbg_gnt;
    o_rf_a3   = w_init ? r_cnt : w_core ? i_core_a3 : w_ld_gnt ? i_ld_addr : w_dbg_gnt ? i_dbg_addr : 5'd0;
    o_rf_wd   = w_init ? (r_cnt == 5'd8 ? INIT_X8 : 32'd0) : w_core ? i_core_wd :
                w_ld_gnt ? i_ld_data : w_dbg_gnt ? i_dbg_data : 32'd0;
    o_ld_ack     = w_ld_gnt;
    o_dbg_ack    = w_dbg_gnt;
    o_core_stall = !w_run;
    o_init_done  = w_run;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= INIT_EN ? S_INIT : S_RUN;
      r_cnt   <= 5'd1;
      r_rr    <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_state <= S_RUN;
    end else if (w_ld_gnt) begin
      r_rr <= 1'b1;
    end else if (w_dbg_gnt) begin
      r_rr <= 1'b0;
    end
  end
endmodule

// File: doc/regfile_port_sched.md
# regfile_port_sched

Write-port scheduler for the multi-cycle RISC-V register file. After reset it sweeps x1..x31 to known values, with x8 preloaded to the array-head address. It then shares the register file's single write port between three requesters:
- core writeback, at fixed top priority;
- the program/data loader and the debug port, round-robin between the two.

It sits directly in front of the register file's we/a3/wd inputs.

## Interface
- INIT_EN, 1: 1 = run the post-reset clear sweep; 0 = enter RUN immediately after reset.
- INIT_X8, 32'h0000_0048: value written to x8 during the sweep (array-head pointer).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_we  in  1  core writeback request (single cycle, no handshake).
- core_a3  in  5  core destination register.
- core_wd  in  32  core write data.
- core_stall  out  1  1 while the sweep runs or rst is low; the controller must hold fetch.
- ld_req  in  1  loader write request; held until ld_ack.
- ld_addr  in  5  loader destination register.
- ld_data  in  32  loader write data.
- ld_ack  out  1  one-cycle pulse in the cycle the loader write is driven.
- dbg_req  in  1  debug write request; held until dbg_ack.
- dbg_addr  in  5  debug destination register.
- dbg_data  in  32  debug write data.
- dbg_ack  out  1  one-cycle pulse in the cycle the debug write is driven.
- rf_we  out  1  register-file write enable.
- rf_a3  out  5  register-file write address.
- rf_wd  out  32  register-file write data.
- init_done  out  1  1 when in RUN.

## Operation
- States: INIT and RUN.
- Registers: state, 5-bit counter cnt, 1-bit round-robin pointer rr (0 = loader next, 1 = debug next).
- Reset (rst low) forces the state to INIT (or RUN if INIT_EN=0), cnt=1, rr=0.
- While rst is low, all outputs are gated: rf_we=0, rf_a3=0, rf_wd=0, ld_ack=0, dbg_ack=0, init_done=0, core_stall=1.
- INIT:
  - Drives rf_we=1, rf_a3=cnt, rf_wd = INIT_X8 when cnt==8, else 0.
  - cnt increments on each edge. The edge at cnt==31 moves the state to RUN.
  - core_stall=1; ld_ack=0, dbg_ack=0.
  - core_we, ld_req and dbg_req are ignored. Loader/debug requests stay pending until RUN.
- RUN, combinational grant each cycle:
  - core_we=1: rf_we=1, rf_a3=core_a3, rf_wd=core_wd. No ack is issued; rr is unchanged.
  - Otherwise, if exactly one of ld_req/dbg_req is high, that requester is granted.
  - If both are high, rr picks the winner.
  - The granted requester drives rf_a3/rf_wd from its addr/data, and its ack is 1 for that cycle.
  - On the clock edge after a loader or debug grant, rr is set to point at the other requester.
  - With no request: rf_we=0, rf_a3=0, rf_wd=0.
- Writes to address 0 are passed through and acknowledged normally; the register file discards them.
- A requester that keeps req high after its ack is treated as a new request. Starvation is bounded: with both low-priority requesters active, each is granted within 2 non-core cycles.
- core_stall=0 and init_done=1 throughout RUN.

## Timing
- Sweep: 31 writes (x1..x31) on the first 31 rising edges after rst deasserts. init_done rises right after the 31st edge.
- RUN grant path is zero latency: request in cycle N means the write is committed at the end of cycle N, and the ack is high in cycle N.
- Minimum loader/debug write interval is 1 cycle; core writes in consecutive cycles block both.
- Asynchronous reset mid-sweep or mid-grant aborts immediately. Acks and rf_we drop in the same instant and the sweep restarts from x1.
- A pending request is not lost across reset; the requester is expected to hold it.

## Test plan
- Reset release with INIT_EN=1, INIT_X8=0x48:
  - rf_we=1 for exactly 31 cycles, rf_a3 stepping 1..31.
  - rf_wd=0x48 only at a3=8.
  - init_done rises on cycle 31; the register file then reads x8=0x48 and x5=0.
- core_we=1 (a3=3, wd=0xDEAD_BEEF) together with ld_req=1 (addr=4):
  - The core write is issued and ld_ack=0.
  - In the next cycle, with core_we=0, ld_ack=1 and x4 is written.
- ld_req and dbg_req held high for 4 cycles, with core idle:
  - Acks alternate ld, dbg, ld, dbg.
  - rf_a3 tracks the granted requester's address each cycle.
- core_we and ld_req asserted during the sweep:
  - core_stall=1 and no ack is issued.
  - ld_ack occurs in the first RUN cycle.
- rst pulsed low at sweep cnt=12:
  - rf_we=0 immediately.
  - After release, the sweep restarts at x1 and runs a full 31 cycles.
- dbg_req to addr 0 with data 0xFFFF_FFFF:
  - dbg_ack=1 with rf_we=1 and rf_a3=0.
  - x0 still reads 0.
